// File: rtl/fmc_clk_monitor.sv
// Frequency monitor for the looped-back FMC clock: counts synchronized rising edges
// over a fixed window of i_clk cycles and checks the count against a pass range.
module fmc_clk_monitor #(
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_W         = 16,
  parameter int EXP_MIN       = 250,
  parameter int EXP_MAX       = 262,
  parameter int PASS_REQ      = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_fmc_clk,
  output logic [CNT_W-1:0] o_edge_count,
  output logic             o_count_valid,
  output logic             o_in_range,
  output logic             o_locked,
  output logic [7:0]       o_fail_count
);
  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  // one spare code so streak+1 never wraps before the compare
  localparam int STK_W = $clog2(PASS_REQ + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, EVAL} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sync_q, sync_d;       // [0]=s1, [1]=s2, [2]=s3
  logic [WIN_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STK_W-1:0]  stk_q, stk_d;
  logic [CNT_W-1:0]  ecnt_q, ecnt_d;
  logic              vld_q, vld_d;
  logic              inr_q, inr_d;
  logic              lock_q, lock_d;
  logic [7:0]        fail_q, fail_d;
  logic              fmc_rise;
  logic              pass;

  assign fmc_rise = sync_q[1] & ~sync_q[2];
  assign pass     = (cnt_q >= CNT_W'(EXP_MIN)) && (cnt_q <= CNT_W'(EXP_MAX));

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[1:0], i_fmc_clk};
    win_d   = win_q;
    cnt_d   = cnt_q;
    stk_d   = stk_q;
    ecnt_d  = ecnt_q;
    vld_d   = 1'b0;
    inr_d   = inr_q;
    lock_d  = lock_q;
    fail_d  = fail_q;
    if (!i_en) begin
      // disable aborts the open window, even in the EVAL cycle
      state_d = IDLE;
      stk_d   = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = MEASURE;
          win_d   = '0;
          cnt_d   = '0;
        end
        MEASURE: begin
          win_d = win_q + 1'b1;
          if (fmc_rise && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (win_q == WIN_LAST) state_d = EVAL;
        end
        EVAL: begin
          ecnt_d = cnt_q;
          vld_d  = 1'b1;
          inr_d  = pass;
          if (pass) begin
            if (stk_q < STK_W'(PASS_REQ)) stk_d = stk_q + 1'b1;
            lock_d = (stk_q + 1'b1) >= STK_W'(PASS_REQ);
          end else begin
            stk_d  = '0;
            lock_d = 1'b0;
            if (fail_q != 8'hFF) fail_d = fail_q + 1'b1;
          end
          win_d   = '0;
          cnt_d   = '0;
          state_d = MEASURE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      stk_q   <= '0;
      ecnt_q  <= '0;
      vld_q   <= 1'b0;
      inr_q   <= 1'b0;
      lock_q  <= 1'b0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      stk_q   <= stk_d;
      ecnt_q  <= ecnt_d;
      vld_q   <= vld_d;
      inr_q   <= inr_d;
      lock_q  <= lock_d;
      fail_q  <= fail_d;
    end
  end

  assign o_edge_count  = ecnt_q;
  assign o_count_valid = vld_q;
  assign o_in_range    = inr_q;
  assign o_locked      = lock_q;
  assign o_fail_count  = fail_q;
endmodule

// File: tb/tb_fmc_clk_monitor.sv
// Randomized bench for fmc_clk_monitor: a sample-history reference model predicts every
// output each cycle; directed phases cover lock, frequency change, disable, reset, saturation.
`timescale 1ns/100ps
module tb_fmc_clk_monitor;
  localparam int W    = 64;
  localparam int CW   = 16;
  localparam int EMIN = 14;
  localparam int EMAX = 18;
  localparam int PR   = 4;
  localparam int MAXC = 60000;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, fmc = 1'b0;
  logic [CW-1:0] o_edge_count;
  logic          o_count_valid, o_in_range, o_locked;
  logic [7:0]    o_fail_count;

  always #1 clk = ~clk;

  fmc_clk_monitor #(.WINDOW_CYCLES(W), .CNT_W(CW), .EXP_MIN(EMIN), .EXP_MAX(EMAX),
                    .PASS_REQ(PR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_fmc_clk(fmc),
    .o_edge_count(o_edge_count), .o_count_valid(o_count_valid), .o_in_range(o_in_range),
    .o_locked(o_locked), .o_fail_count(o_fail_count));

  int errs = 0, checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: samp[k] is the FMC level seen at clock edge k; a rise is
  // visible to the counter two edges later. A window opened at edge e0 covers the
  // rises formed by samples (k-2,k-1) for k in [e0, e0+W) and reports at e0+W+1.
  bit samp[MAXC];
  int n = 0, zero_below = 0, e0 = 0, streak = 0;
  bit open_w = 0;
  int m_cnt = 0, m_fail = 0;
  bit m_vld = 0, m_inr = 0, m_lock = 0;

  function automatic bit f(input int k);
    return (k < zero_below || k < 0 || k >= MAXC) ? 1'b0 : samp[k];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_w = 0; streak = 0; m_cnt = 0; m_fail = 0;
      m_vld = 0; m_inr = 0; m_lock = 0; zero_below = n;
    end else begin
      if (n < MAXC) samp[n] = fmc;
      m_vld = 0;
      if (!en) begin
        open_w = 0; streak = 0; m_lock = 0;
      end else if (!open_w) begin
        open_w = 1; e0 = n;
      end else if (n == e0 + W + 1) begin
        int c;
        c = 0;
        for (int k = e0; k < e0 + W; k++) if (f(k-1) && !f(k-2)) c++;
        if (c > (1 << CW) - 1) c = (1 << CW) - 1;
        m_cnt = c;
        m_inr = (c >= EMIN) && (c <= EMAX);
        m_vld = 1;
        if (m_inr) begin
          streak = (streak + 1 > PR) ? PR : streak + 1;
          m_lock = (streak >= PR);
        end else begin
          streak = 0; m_lock = 0;
          if (m_fail < 255) m_fail++;
        end
        e0 = n;
      end
      n++;
    end
  end

  // FMC stimulus: 0 = square wave with half-period hp cycles, 1 = stuck low, 2 = random bits
  int mode = 0, hp = 2, ph = 0;

  task automatic tick();
    @(negedge clk);
    chk("valid",    o_count_valid, m_vld);
    chk("count",    o_edge_count,  m_cnt);
    chk("in_range", o_in_range,    m_inr);
    chk("locked",   o_locked,      m_lock);
    chk("fail_cnt", o_fail_count,  m_fail);
    case (mode)
      0:       fmc = ((ph / hp) % 2) == 1;
      1:       fmc = 1'b0;
      default: fmc = 1'($urandom_range(0, 1));
    endcase
    ph++;
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  // waits for the next pulse; returns the number of ticks taken (0 on timeout)
  task automatic wait_pulse(input string tag, output int lat);
    lat = 0;
    for (int i = 1; i <= 3 * (W + 1); i++) begin
      tick();
      if (o_count_valid) begin lat = i; break; end
    end
    if (lat == 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_count"},  o_edge_count,  0);
    chk({tag, "_valid"},  o_count_valid, 0);
    chk({tag, "_inr"},    o_in_range,    0);
    chk({tag, "_locked"}, o_locked,      0);
    chk({tag, "_fail"},   o_fail_count,  0);
  endtask

  initial begin
    int lat, fail0, hold, pulses;
    run(4);
    chk_zero("reset");
    rst_n = 1'b1;
    run(3);

    // 1) nominal frequency: 16 rises per window, lock on the 4th report
    mode = 0; hp = 2; en = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6 * (W + 1) && pulses < 4; i++) begin
      tick();
      if (o_count_valid) begin
        pulses++;
        if (pulses == 1) chk("t1_first_latency", i + 1, W + 2);
        if (pulses == 3) chk("t1_not_locked_yet", o_locked, 0);
      end
    end
    chk("t1_pulses", pulses, 4);
    chk("t1_locked", o_locked, 1);
    chk("t1_count", o_edge_count, 16);
    chk("t1_fail", o_fail_count, 0);
    run(W / 3);

    // 3) halve the frequency while locked
    hp = 4;
    wait_pulse("t3a", lat);
    fail0 = m_fail;
    wait_pulse("t3b", lat);
    chk("t3_period", lat, W + 1);
    chk("t3_count", o_edge_count, 8);
    chk("t3_in_range", o_in_range, 0);
    chk("t3_locked", o_locked, 0);
    chk("t3_fail_inc", o_fail_count, fail0 + 1);

    // 4) disable mid-window, then re-enable
    hp = 2;
    wait_pulse("t4a", lat);
    run(W / 2);
    hold = m_cnt;
    en = 1'b0;
    run(20);
    chk("t4_hold", o_edge_count, hold);
    chk("t4_locked", o_locked, 0);
    en = 1'b1;
    wait_pulse("t4b", lat);
    chk("t4_latency", lat, W + 2);

    // 5) async reset mid-window while locked
    run(5 * (W + 1));
    chk("t5_locked_pre", o_locked, 1);
    run(W / 2);
    rst_n = 1'b0;
    #0.2;
    chk_zero("t5_async");
    run(3);
    rst_n = 1'b1;
    wait_pulse("t5", lat);
    chk("t5_latency", lat, W + 2);

    // randomized mix of frequencies, patterns, disables and resets
    for (int r = 0; r < 14; r++) begin
      int sel;
      mode = $urandom_range(0, 2);
      hp   = $urandom_range(1, 6);
      ph   = $urandom_range(0, 100);
      run($urandom_range(10, 3 * W));
      sel = $urandom_range(0, 7);
      if (sel < 2) begin
        en = 1'b0; run($urandom_range(1, 8)); en = 1'b1;
      end else if (sel == 2) begin
        rst_n = 1'b0; run($urandom_range(1, 3)); rst_n = 1'b1;
      end
    end

    // 2) stuck-low clock: every window fails, fail counter saturates at 255
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    mode = 1;
    run(258 * (W + 1) + W + 2);
    chk("t2_fail_sat", o_fail_count, 255);
    chk("t2_count", o_edge_count, 0);
    chk("t2_in_range", o_in_range, 0);
    chk("t2_locked", o_locked, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
